// File: rtl/fifo_csr_pkg.sv
// Shared register-map constants and flush FSM state type for the FIFO CSR bank.
package fifo_csr_pkg;

  localparam int unsigned CH_STRIDE = 8;
  localparam int unsigned OFF_W     = $clog2(CH_STRIDE);

  localparam logic [OFF_W-1:0] CTRL   = OFF_W'(0);
  localparam logic [OFF_W-1:0] STATUS = OFF_W'(1);
  localparam logic [OFF_W-1:0] THRESH = OFF_W'(2);
  localparam logic [OFF_W-1:0] IRQ    = OFF_W'(3);
  localparam logic [OFF_W-1:0] LEVEL  = OFF_W'(4);

  localparam int unsigned IRQ_W   = 4;
  localparam int unsigned IRQ_OVF = 0;
  localparam int unsigned IRQ_UDF = 1;
  localparam int unsigned IRQ_AF  = 2;
  localparam int unsigned IRQ_TMO = 3;

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} flush_state_t;

endpackage

// File: rtl/fifo_csr_chan.sv
// One channel of the FIFO CSR bank: control/threshold/irq registers and flush FSM.
// FIFO_CSR_FLUSH_TIMEOUT_EN adds a flush-ack timeout that sets IRQ bit3.
module fifo_csr_chan
  import fifo_csr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned LEVEL_W       = 5,
  parameter int unsigned FLUSH_TIMEOUT = 64
) (
  input  logic                  csr_clk,
  input  logic                  csr_resetn,
  input  logic                  wr_en,
  input  logic [OFF_W-1:0]      wr_off,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [OFF_W-1:0]      rd_off,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic                  empty,
  input  logic                  full,
  input  logic [LEVEL_W-1:0]    level,
  input  logic                  overflow,
  input  logic                  underflow,
  input  logic                  flush_ack,
  output logic                  flush_req,
  output logic                  enable,
  output logic                  almost_full,
  output logic                  irq
);

`ifdef FIFO_CSR_FLUSH_TIMEOUT_EN
  localparam logic [IRQ_W-1:0] IRQ_IMPL = 4'b1111;
  localparam int unsigned      CNT_W    = $clog2(FLUSH_TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  localparam logic [IRQ_W-1:0] IRQ_IMPL = 4'b0111;
  logic [31:0] unused_tmo;
  assign unused_tmo = 32'(FLUSH_TIMEOUT);
`endif

  flush_state_t        state_q, state_d;
  logic                flush_req_q, flush_req_d;
  logic                enable_q, enable_d;
  logic [IRQ_W-1:0]    mask_q, mask_d;
  logic [LEVEL_W-1:0]  thresh_q, thresh_d;
  logic                af_q, af_d;
  logic [IRQ_W-1:0]    irq_q, irq_d;
  logic [IRQ_W-1:0]    irq_set, irq_clr;
  logic                wr_ctrl, wr_thresh, wr_irq, tmo;
  logic [DATA_WIDTH-1:0] unused_wdata;

  assign unused_wdata = wdata;

  always_comb begin
    state_d   = state_q;
    enable_d  = enable_q;
    mask_d    = mask_q;
    thresh_d  = thresh_q;
    tmo       = 1'b0;
    wr_ctrl   = wr_en && (wr_off == CTRL);
    wr_thresh = wr_en && (wr_off == THRESH);
    wr_irq    = wr_en && (wr_off == IRQ);

    if (wr_ctrl) begin
      enable_d = wdata[1];
      mask_d   = wdata[5:2] & IRQ_IMPL;
    end
    if (wr_thresh) thresh_d = wdata[LEVEL_W-1:0];

    // A flush request write only starts from IDLE; a 0 in bit0 never aborts.
    case (state_q)
      IDLE:  if (wr_ctrl && wdata[0]) state_d = REQ;
      REQ: begin
        if (flush_ack) state_d = DRAIN;
`ifdef FIFO_CSR_FLUSH_TIMEOUT_EN
        else if (cnt_q == CNT_W'(FLUSH_TIMEOUT - 1)) begin
          state_d = IDLE;
          tmo     = 1'b1;
        end
`endif
      end
      DRAIN: if (!flush_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef FIFO_CSR_FLUSH_TIMEOUT_EN
    cnt_d = (state_q == REQ) ? cnt_q + 1'b1 : '0;
`endif

    flush_req_d = (state_d == REQ);
    af_d        = (thresh_q != '0) && (level >= thresh_q);

    irq_set          = '0;
    irq_set[IRQ_OVF] = overflow;
    irq_set[IRQ_UDF] = underflow;
    irq_set[IRQ_AF]  = af_d && !af_q;
    irq_set[IRQ_TMO] = tmo;
    irq_clr          = wr_irq ? wdata[IRQ_W-1:0] : '0;
    irq_d            = ((irq_q & ~irq_clr) | irq_set) & IRQ_IMPL;
  end

  always_ff @(posedge csr_clk or negedge csr_resetn) begin
    if (!csr_resetn) begin
      state_q     <= IDLE;
      flush_req_q <= 1'b0;
      enable_q    <= 1'b1;
      mask_q      <= '0;
      thresh_q    <= '0;
      af_q        <= 1'b0;
      irq_q       <= '0;
`ifdef FIFO_CSR_FLUSH_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      flush_req_q <= flush_req_d;
      enable_q    <= enable_d;
      mask_q      <= mask_d;
      thresh_q    <= thresh_d;
      af_q        <= af_d;
      irq_q       <= irq_d;
`ifdef FIFO_CSR_FLUSH_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  always_comb begin
    rdata = '0;
    case (rd_off)
      CTRL: begin
        rdata[0]   = (state_q != IDLE);
        rdata[1]   = enable_q;
        rdata[5:2] = mask_q;
      end
      STATUS:  rdata[2:0] = {af_q, full, empty};
      THRESH:  rdata[LEVEL_W-1:0] = thresh_q;
      IRQ:     rdata[IRQ_W-1:0] = irq_q;
      LEVEL:   rdata[LEVEL_W-1:0] = level;
      default: rdata = '0;
    endcase
  end

  assign flush_req   = flush_req_q;
  assign enable      = enable_q;
  assign almost_full = af_q;
  assign irq         = |(irq_q & mask_q);

endmodule

// File: rtl/fifo_csr_bank.sv
// Multi-channel FIFO CSR bank: address decode, registered read mux and irq combine.
// Define FIFO_CSR_FLUSH_TIMEOUT_EN to enable the per-channel flush-ack timeout.
module fifo_csr_bank
  import fifo_csr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDR_WIDTH    = 8,
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned LEVEL_W       = 5,
  parameter int unsigned FLUSH_TIMEOUT = 64
) (
  input  logic                        csr_clk,
  input  logic                        csr_resetn,
  input  logic [ADDR_WIDTH-1:0]       reg_w_addr,
  input  logic [DATA_WIDTH-1:0]       reg_wdata,
  input  logic                        reg_write_enable,
  input  logic [ADDR_WIDTH-1:0]       reg_r_addr,
  input  logic                        reg_read_enable,
  output logic [DATA_WIDTH-1:0]       reg_rdata,
  input  logic [NUM_CH-1:0]           fifo_empty,
  input  logic [NUM_CH-1:0]           fifo_full,
  input  logic [NUM_CH*LEVEL_W-1:0]   fifo_level,
  input  logic [NUM_CH-1:0]           fifo_overflow,
  input  logic [NUM_CH-1:0]           fifo_underflow,
  input  logic [NUM_CH-1:0]           flush_ack,
  output logic [NUM_CH-1:0]           flush_req,
  output logic [NUM_CH-1:0]           fifo_enable,
  output logic [NUM_CH-1:0]           almost_full,
  output logic                        irq
);

  localparam int unsigned CH_W = ADDR_WIDTH - OFF_W;

  logic [CH_W-1:0]       w_ch, r_ch;
  logic [OFF_W-1:0]      w_off, r_off;
  logic                  w_hit;
  logic [DATA_WIDTH-1:0] chan_rdata [NUM_CH];
  logic [NUM_CH-1:0]     chan_irq;
  logic [DATA_WIDTH-1:0] reg_rdata_q, reg_rdata_d;

  assign w_ch  = reg_w_addr[ADDR_WIDTH-1:OFF_W];
  assign w_off = reg_w_addr[OFF_W-1:0];
  assign r_ch  = reg_r_addr[ADDR_WIDTH-1:OFF_W];
  assign r_off = reg_r_addr[OFF_W-1:0];
  assign w_hit = reg_write_enable && (32'(w_ch) < NUM_CH);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
    fifo_csr_chan #(
      .DATA_WIDTH    (DATA_WIDTH),
      .LEVEL_W       (LEVEL_W),
      .FLUSH_TIMEOUT (FLUSH_TIMEOUT)
    ) u_chan (
      .csr_clk     (csr_clk),
      .csr_resetn  (csr_resetn),
      .wr_en       (w_hit && (w_ch == CH_W'(k))),
      .wr_off      (w_off),
      .wdata       (reg_wdata),
      .rd_off      (r_off),
      .rdata       (chan_rdata[k]),
      .empty       (fifo_empty[k]),
      .full        (fifo_full[k]),
      .level       (fifo_level[k*LEVEL_W +: LEVEL_W]),
      .overflow    (fifo_overflow[k]),
      .underflow   (fifo_underflow[k]),
      .flush_ack   (flush_ack[k]),
      .flush_req   (flush_req[k]),
      .enable      (fifo_enable[k]),
      .almost_full (almost_full[k]),
      .irq         (chan_irq[k])
    );
  end

  // Channel read data reflects pre-edge register state, so a same-cycle write is not seen.
  always_comb begin
    reg_rdata_d = reg_rdata_q;
    if (reg_read_enable) begin
      reg_rdata_d = '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (32'(r_ch) == k) reg_rdata_d = chan_rdata[k];
      end
    end
  end

  always_ff @(posedge csr_clk or negedge csr_resetn) begin
    if (!csr_resetn) reg_rdata_q <= '0;
    else             reg_rdata_q <= reg_rdata_d;
  end

  assign reg_rdata = reg_rdata_q;
  assign irq       = |chan_irq;

endmodule
